// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: raster-order job scheduler feeding depth_engine and a valid/ready pixel stream.
// Optional ITER_SUM_EN adds a per-frame running total of engine depths on iter_sum.
module pixel_dispatcher #(
    parameter int FRAC  = 8,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [7:0]  max_iter,
    input  logic [15:0] re_origin,
    input  logic [15:0] im_origin,
    input  logic [15:0] step,
    output logic        eng_start,
    output logic [9:0]  eng_x,
    output logic [8:0]  eng_y,
    output logic [15:0] eng_re_c,
    output logic [15:0] eng_im_c,
    output logic [7:0]  eng_max_iter,
    input  logic [7:0]  eng_depth,
    input  logic        eng_done,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_depth,
    output logic        pix_last,
`ifdef ITER_SUM_EN
    output logic [31:0] iter_sum,
`endif
    output logic        busy
);
    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

    // Coordinates must share the engine's 16-bit Q format.
    if (FRAC < 1 || FRAC > 15) begin : g_frac_unsupported
        $error("pixel_dispatcher: FRAC must be 1..15");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;
    state_t state, state_nx;

    logic [9:0]  x;
    logic [8:0]  y;
    logic [15:0] re_acc, im_acc, re_org, step_r;
    logic        last;

    assign last = (x == X_MAX) && (y == Y_MAX);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_start ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = eng_done ? EMIT : WAIT;
            default: state_nx = pix_ready ? (last ? IDLE : ISSUE) : EMIT;
        endcase
    end

    always_comb begin
        eng_start = state == ISSUE;
        pix_valid = state == EMIT;
        busy      = state != IDLE;
        pix_last  = pix_valid && last;
    end

    assign eng_x    = x;
    assign eng_y    = y;
    assign eng_re_c = re_acc;
    assign eng_im_c = im_acc;
    assign pix_x    = x;
    assign pix_y    = y;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            x            <= '0;
            y            <= '0;
            re_acc       <= '0;
            im_acc       <= '0;
            re_org       <= '0;
            step_r       <= '0;
            eng_max_iter <= '0;
            pix_depth    <= '0;
`ifdef ITER_SUM_EN
            iter_sum     <= '0;
`endif
        end else begin
            if (state == IDLE && frame_start) begin
                x            <= '0;
                y            <= '0;
                re_acc       <= re_origin;
                im_acc       <= im_origin;
                re_org       <= re_origin;
                step_r       <= step;
                eng_max_iter <= max_iter;
`ifdef ITER_SUM_EN
                iter_sum     <= '0;
`endif
            end
            if (state == WAIT && eng_done) begin
                pix_depth <= eng_depth;
`ifdef ITER_SUM_EN
                iter_sum  <= iter_sum + 32'(eng_depth);
`endif
            end
            // Imaginary axis decreases going down the frame.
            if (state == EMIT && pix_ready && !last) begin
                if (x == X_MAX) begin
                    x      <= '0;
                    y      <= y + 9'd1;
                    re_acc <= re_org;
                    im_acc <= im_acc - step_r;
                end else begin
                    x      <= x + 10'd1;
                    re_acc <= re_acc + step_r;
                end
            end
        end
    end
endmodule
